spi_master_txn_ctrl: RTL and testbench

- Transaction sequencer in front of the existing byte-level SPI master.
- Takes a start request with a byte count, pulls TX bytes from a valid/ready stream, and feeds them to the master one at a time with its TX_DV/TX_Ready handshake.
- Owns chip select, with programmable setup, hold and inter-transaction gap times.
- Returns every byte received on MISO as a one-cycle valid stream.

---
 rtl/spi_master_txn_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_master_txn_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_txn_ctrl.sv
// Transaction sequencer in front of the byte-level SPI master: owns chip select timing,
// feeds TX stream bytes to the master one at a time and forwards every received byte.
module spi_master_txn_ctrl #(
   parameter int unsigned LEN_W         = 8,
   parameter int unsigned CS_SETUP_CLKS = 4,
   parameter int unsigned CS_HOLD_CLKS  = 4,
   parameter int unsigned CS_GAP_CLKS   = 8
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_Start,
   input  logic [LEN_W-1:0] i_Len,
   output logic             o_Busy,
   output logic             o_Done,
   input  logic             i_Data_Valid,
   input  logic [7:0]       i_Data,
   output logic             o_Data_Ready,
   output logic             o_RX_Valid,
   output logic [7:0]       o_RX_Byte,
   output logic             o_M_TX_DV,
   output logic [7:0]       o_M_TX_Byte,
   input  logic             i_M_TX_Ready,
   input  logic             i_M_RX_DV,
   input  logic [7:0]       i_M_RX_Byte,
   output logic             o_SPI_CS_n
);

   localparam int unsigned SetupHold = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS
                                                                       : CS_HOLD_CLKS;
   localparam int unsigned CntMax    = (SetupHold > CS_GAP_CLKS) ? SetupHold : CS_GAP_CLKS;
   localparam int unsigned CntW      = $clog2(CntMax + 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StLoad,
      StWaitByte,
      StHold,
      StGap
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tx_dv_q, tx_dv_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             rx_valid_q, rx_valid_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             cnt_last;

   // A counter loaded with N keeps its state for exactly N cycles.
   assign cnt_last = (cnt_q <= CntW'(1));

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         remaining_q <= '0;
         cs_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_byte_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         remaining_q <= remaining_d;
         cs_n_q      <= cs_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_byte_q   <= rx_byte_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      remaining_d = remaining_q;
      cs_n_d      = cs_n_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      tx_dv_d     = 1'b0;
      tx_byte_d   = tx_byte_q;
      rx_valid_d  = 1'b0;
      rx_byte_d   = rx_byte_q;

      case (state_q)
         StIdle: begin
            if (i_Start) begin
               if (i_Len != '0) begin
                  remaining_d = i_Len;
                  cs_n_d      = 1'b0;
                  busy_d      = 1'b1;
                  cnt_d       = CntW'(CS_SETUP_CLKS);
                  state_d     = StSetup;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StSetup: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (i_Data_Valid && i_M_TX_Ready) begin
               tx_byte_d = i_Data;
               tx_dv_d   = 1'b1;
               state_d   = StWaitByte;
            end
         end
         StWaitByte: begin
            if (i_M_RX_DV) begin
               rx_byte_d   = i_M_RX_Byte;
               rx_valid_d  = 1'b1;
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  cnt_d   = CntW'(CS_HOLD_CLKS);
                  state_d = StHold;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StHold: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_last) begin
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               cnt_d   = CntW'(CS_GAP_CLKS);
               state_d = StGap;
            end
         end
         StGap: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_last) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Ready passes straight through so a byte is only taken when the master can accept it.
   assign o_Data_Ready = (state_q == StLoad) && i_M_TX_Ready;

   assign o_Busy      = busy_q;
   assign o_Done      = done_q;
   assign o_RX_Valid  = rx_valid_q;
   assign o_RX_Byte   = rx_byte_q;
   assign o_M_TX_DV   = tx_dv_q;
   assign o_M_TX_Byte = tx_byte_q;
   assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_master_txn_ctrl.sv
// Bench for spi_master_txn_ctrl: directed table, reset/stray sequences and randomized
// transactions against a loopback slave and a queue-based reference model.
module tb_spi_master_txn_ctrl;

   localparam int SETUP = 4;
   localparam int HOLD  = 4;
   localparam int GAP   = 8;

   logic       r_Clk = 1'b0;
   logic       i_Rst;
   logic       i_Start;
   logic [7:0] i_Len;
   logic       o_Busy;
   logic       o_Done;
   logic       i_Data_Valid;
   logic [7:0] i_Data;
   logic       o_Data_Ready;
   logic       o_RX_Valid;
   logic [7:0] o_RX_Byte;
   logic       o_M_TX_DV;
   logic [7:0] o_M_TX_Byte;
   logic       i_M_TX_Ready;
   logic       i_M_RX_DV;
   logic [7:0] i_M_RX_Byte;
   logic       o_SPI_CS_n;

   always #5 r_Clk = ~r_Clk;

   spi_master_txn_ctrl #(
      .LEN_W         (8),
      .CS_SETUP_CLKS (SETUP),
      .CS_HOLD_CLKS  (HOLD),
      .CS_GAP_CLKS   (GAP)
   ) dut (
      .i_Clk        (r_Clk),
      .i_Rst        (i_Rst),
      .i_Start      (i_Start),
      .i_Len        (i_Len),
      .o_Busy       (o_Busy),
      .o_Done       (o_Done),
      .i_Data_Valid (i_Data_Valid),
      .i_Data       (i_Data),
      .o_Data_Ready (o_Data_Ready),
      .o_RX_Valid   (o_RX_Valid),
      .o_RX_Byte    (o_RX_Byte),
      .o_M_TX_DV    (o_M_TX_DV),
      .o_M_TX_Byte  (o_M_TX_Byte),
      .i_M_TX_Ready (i_M_TX_Ready),
      .i_M_RX_DV    (i_M_RX_DV),
      .i_M_RX_Byte  (i_M_RX_Byte),
      .o_SPI_CS_n   (o_SPI_CS_n)
   );

   typedef struct packed {
      int             len;
      logic [5:0][7:0] data;
      logic [5:0][7:0] rx;
      int             stall_at;
      int             stall_len;
      bit             mid_start;
   } vec_t;

   int         checks, failures, cyc;
   logic [7:0] src_q[$];
   logic [7:0] exp_rx_q[$];
   int         tx_seen, rx_seen, done_seen, txn_tx;
   int         stall_at, stall_len, stall_cnt;
   logic       m_ready;
   int         m_cnt, lat_min, lat_max;
   logic [7:0] m_cur, slave_sr, ref_sr;
   bit         stray_pending;
   logic       cs_prev, busy_prev, dv_prev;
   bit         have_rise, first_tx_pending;
   int         t_fall, t_rise, t_rx, t_done;

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_msg(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
   endtask

   // One clock of the environment: monitor DUT outputs, then step master and source.
   task automatic tick();
      @(negedge r_Clk);
      cyc++;
      if (i_Rst) begin
         src_q.delete();
         exp_rx_q.delete();
         m_ready = 1'b1;  m_cnt = 0;  slave_sr = 8'h5A;  stall_cnt = 0;
         cs_prev = 1'b1;  busy_prev = 1'b0;  dv_prev = 1'b0;
         have_rise = 1'b0;  first_tx_pending = 1'b0;
         i_M_RX_DV = 1'b0;  i_M_TX_Ready = 1'b1;  i_Data_Valid = 1'b0;
         return;
      end
      if (o_M_TX_DV) begin
         check_bit("tx_dv_one_cycle", dv_prev, 1'b0);
         check_bit("tx_dv_needs_valid", i_Data_Valid, 1'b1);
         check_bit("tx_dv_needs_ready", m_ready, 1'b1);
         if (src_q.size() == 0) fail_msg("tx_dv_extra", "TX_DV with no byte offered, expected none");
         else check_byte("tx_byte", o_M_TX_Byte, src_q.pop_front());
         if (first_tx_pending) begin
            check_bit("cs_setup_time", (cyc - t_fall) >= SETUP, 1'b1);
            first_tx_pending = 1'b0;
         end
         tx_seen++;
         txn_tx++;
         if (txn_tx == stall_at) stall_cnt = stall_len + 1;
      end
      dv_prev = o_M_TX_DV;
      if (o_RX_Valid) begin
         if (exp_rx_q.size() == 0) fail_msg("rx_unexpected", "RX_Valid pulse, expected none");
         else check_byte("rx_byte", o_RX_Byte, exp_rx_q.pop_front());
         rx_seen++;
         t_rx = cyc;
      end
      if (o_Data_Ready)
         check_bit("data_ready_gated", i_M_TX_Ready && !o_SPI_CS_n && !o_M_TX_DV, 1'b1);
      if (cs_prev && !o_SPI_CS_n) begin
         if (have_rise) check_bit("cs_gap_time", (cyc - t_rise) >= GAP + 1, 1'b1);
         t_fall = cyc;
         first_tx_pending = 1'b1;
      end
      if (!cs_prev && o_SPI_CS_n) begin
         check_int("cs_hold_time", cyc - t_rx, HOLD);
         check_bit("done_at_cs_rise", o_Done, 1'b1);
         t_rise = cyc;
         have_rise = 1'b1;
      end
      if (!o_SPI_CS_n) check_bit("busy_while_cs_low", o_Busy, 1'b1);
      if (o_Done) begin
         done_seen++;
         t_done = cyc;
      end
      if (busy_prev && !o_Busy) check_int("busy_after_done", cyc - t_done, GAP);
      cs_prev   = o_SPI_CS_n;
      busy_prev = o_Busy;
      // Byte-level master with a loopback slave that returns the previous byte it received.
      i_M_RX_DV = 1'b0;
      if (m_cnt != 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            i_M_RX_DV   = 1'b1;
            i_M_RX_Byte = slave_sr;
            slave_sr    = m_cur;
         end
      end else if (!m_ready) begin
         m_ready = 1'b1;
      end else if (stray_pending && o_SPI_CS_n) begin
         i_M_RX_DV     = 1'b1;
         i_M_RX_Byte   = 8'hE7;
         stray_pending = 1'b0;
      end
      if (o_M_TX_DV) begin
         m_ready = 1'b0;
         m_cur   = o_M_TX_Byte;
         m_cnt   = int'($urandom_range(lat_max, lat_min));
      end
      i_M_TX_Ready = m_ready;
      if (stall_cnt != 0) stall_cnt--;
      i_Data_Valid = (src_q.size() != 0) && (stall_cnt == 0);
      i_Data       = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
   endtask

   // Caller preloads src_q and exp_rx_q; called at a negedge with the DUT idle.
   task automatic run_txn(input int len, input int s_at, input int s_len, input bit mid_start);
      int  done0, tx0, rx0, n;
      bit  mid_done;
      done0 = done_seen;  tx0 = tx_seen;  rx0 = rx_seen;
      stall_at = s_at;  stall_len = s_len;  txn_tx = 0;  mid_done = 1'b0;
      i_Start = 1'b1;
      i_Len   = 8'(len);
      tick();
      i_Start = 1'b0;
      if (len == 0) begin
         check_bit("zero_done_pulse", o_Done, 1'b1);
         check_bit("zero_busy_low", o_Busy, 1'b0);
         check_bit("zero_cs_high", o_SPI_CS_n, 1'b1);
         tick();
         tick();
         check_int("zero_done_count", done_seen - done0, 1);
         check_bit("zero_cs_still_high", o_SPI_CS_n, 1'b1);
         return;
      end
      check_bit("start_busy", o_Busy, 1'b1);
      check_bit("start_cs_low", o_SPI_CS_n, 1'b0);
      n = 0;
      while (done_seen == done0 && n < 5000) begin
         if (mid_start && !mid_done && txn_tx >= 2) begin
            i_Start  = 1'b1;
            i_Len    = 8'd9;
            mid_done = 1'b1;
            tick();
            i_Start  = 1'b0;
         end else begin
            tick();
         end
         n++;
      end
      if (n >= 5000) fail_msg("done_timeout", "no o_Done within 5000 cycles");
      n = 0;
      while (o_Busy && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) fail_msg("busy_timeout", "o_Busy still high after 100 cycles");
      check_int("tx_count", tx_seen - tx0, len);
      check_int("rx_count", rx_seen - rx0, len);
      check_int("done_count", done_seen - done0, 1);
      check_int("rx_leftover", exp_rx_q.size(), 0);
      check_int("src_leftover", src_q.size(), 0);
   endtask

   vec_t vecs[5];

   initial begin
      int done0, rx0, n, len;
      logic [7:0] b;
      checks = 0;  failures = 0;  cyc = 0;
      tx_seen = 0;  rx_seen = 0;  done_seen = 0;  txn_tx = 0;
      stall_at = 0;  stall_len = 0;  stall_cnt = 0;
      m_ready = 1'b1;  m_cnt = 0;  m_cur = 8'h00;  slave_sr = 8'h5A;  stray_pending = 1'b0;
      lat_min = 2;  lat_max = 6;
      cs_prev = 1'b1;  busy_prev = 1'b0;  dv_prev = 1'b0;
      have_rise = 1'b0;  first_tx_pending = 1'b0;
      t_fall = 0;  t_rise = 0;  t_rx = 0;  t_done = 0;
      i_Rst = 1'b1;  i_Start = 1'b0;  i_Len = 8'd0;  i_Data_Valid = 1'b0;  i_Data = 8'd0;
      i_M_TX_Ready = 1'b1;  i_M_RX_DV = 1'b0;  i_M_RX_Byte = 8'd0;
      #1;
      check_bit("rst_cs_n", o_SPI_CS_n, 1'b1);
      check_bit("rst_busy", o_Busy, 1'b0);
      check_bit("rst_done", o_Done, 1'b0);
      check_bit("rst_data_ready", o_Data_Ready, 1'b0);
      check_bit("rst_rx_valid", o_RX_Valid, 1'b0);
      check_byte("rst_rx_byte", o_RX_Byte, 8'h00);
      check_bit("rst_tx_dv", o_M_TX_DV, 1'b0);
      check_byte("rst_tx_byte", o_M_TX_Byte, 8'h00);
      tick();
      tick();
      i_Rst = 1'b0;
      tick();

      vecs[0] = '{len: 1, data: 48'h0000_0000_00C1, rx: 48'h0000_0000_005A,
                  stall_at: 0, stall_len: 0, mid_start: 1'b0};
      vecs[1] = '{len: 6, data: 48'hAA55_FF80_0100, rx: 48'h55FF_8001_00C1,
                  stall_at: 0, stall_len: 0, mid_start: 1'b0};
      vecs[2] = '{len: 3, data: 48'h0000_0033_2211, rx: 48'h0000_0022_11AA,
                  stall_at: 1, stall_len: 50, mid_start: 1'b0};
      vecs[3] = '{len: 0, data: 48'h0, rx: 48'h0, stall_at: 0, stall_len: 0, mid_start: 1'b0};
      vecs[4] = '{len: 4, data: 48'h0000_EFBE_ADDE, rx: 48'h0000_BEAD_DE33,
                  stall_at: 0, stall_len: 0, mid_start: 1'b1};

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < vecs[v].len; i++) begin
            src_q.push_back(vecs[v].data[i]);
            exp_rx_q.push_back(vecs[v].rx[i]);
         end
         run_txn(vecs[v].len, vecs[v].stall_at, vecs[v].stall_len, vecs[v].mid_start);
         if (v == 0) begin
            // A master RX strobe while idle must not leak onto the RX stream.
            rx0 = rx_seen;
            stray_pending = 1'b1;
            for (int k = 0; k < 4; k++) tick();
            check_int("stray_rx_ignored", rx_seen - rx0, 0);
         end
      end

      // Reset while byte 2 of a 4-byte transfer is in flight.
      src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_rx_q = '{8'hEF};
      rx0 = rx_seen;
      done0 = done_seen;
      stall_at = 0;  txn_tx = 0;
      i_Start = 1'b1;
      i_Len   = 8'd4;
      tick();
      i_Start = 1'b0;
      n = 0;
      while (txn_tx < 2 && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) fail_msg("reset_seq_timeout", "second TX_DV never seen");
      check_int("pre_reset_rx", rx_seen - rx0, 1);
      @(posedge r_Clk);
      #2 i_Rst = 1'b1;
      #1;
      check_bit("abort_cs_n", o_SPI_CS_n, 1'b1);
      check_bit("abort_busy", o_Busy, 1'b0);
      check_bit("abort_tx_dv", o_M_TX_DV, 1'b0);
      tick();
      tick();
      i_Rst = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check_int("abort_no_done", done_seen - done0, 0);
      check_bit("abort_idle_cs", o_SPI_CS_n, 1'b1);
      src_q.push_back(8'h3C);
      exp_rx_q.push_back(8'h5A);
      run_txn(1, 0, 0, 1'b0);

      // Randomized transactions checked against the loopback reference.
      ref_sr  = 8'h3C;
      lat_min = 1;
      lat_max = 12;
      for (int t = 0; t < 25; t++) begin
         len = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(12, 1));
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            exp_rx_q.push_back(ref_sr);
            ref_sr = b;
         end
         run_txn(len, int'($urandom_range(12, 0)), int'($urandom_range(20, 0)),
                 (len >= 3) && ($urandom_range(1, 0) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
